// File: rtl/emu_mem_pkg.sv
// Shared types and helpers for the emulation data memory.
// Holds funct3 load/store codes, size decode and load extension.
package emu_mem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_D  = 3'b011;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;
  localparam logic [2:0] RW_WU = 3'b110;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } dmem_state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] nbytes;
  } size_dec_t;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       err;
    logic [2:0] rwtyp;
    logic [2:0] off;
  } dmem_meta_t;

  function automatic size_dec_t size_dec(
    input logic [2:0] t,
    input logic       dw64
  );
    size_dec_t s;
    s.legal  = 1'b1;
    s.nbytes = 4'd1;
    unique case (t)
      RW_B, RW_BU: s.nbytes = 4'd1;
      RW_H, RW_HU: s.nbytes = 4'd2;
      RW_W:        s.nbytes = 4'd4;
      RW_WU: begin
        s.nbytes = 4'd4;
        s.legal  = dw64;
      end
      RW_D: begin
        s.nbytes = 4'd8;
        s.legal  = dw64;
      end
      default: s.legal = 1'b0;
    endcase
    return s;
  endfunction

  // Callers truncate to their word width; w sign-extends only past bit 31.
  function automatic logic [63:0] ext64(
    input logic [63:0] v,
    input logic [2:0]  t
  );
    logic [63:0] r;
    r = v;
    unique case (t)
      RW_B:    r = {{56{v[7]}}, v[7:0]};
      RW_H:    r = {{48{v[15]}}, v[15:0]};
      RW_W:    r = {{32{v[31]}}, v[31:0]};
      RW_BU:   r = {56'd0, v[7:0]};
      RW_HU:   r = {48'd0, v[15:0]};
      RW_WU:   r = {32'd0, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/emu_dmem_array.sv
// Behavioural word storage with byte write enables and registered read.
// Kept separate so a vendor RAM macro can drop in here.
module emu_dmem_array
  import emu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                    clk,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/emu_dmem.sv
// LSU-facing data memory: valid/ready requests, in-order responses,
// load extension, error reporting and optional zero-fill after reset.
module emu_dmem
  import emu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 16,
  parameter int RD_LATENCY = 1,
  parameter int INIT_ZERO  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_rwtyp,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int HI    = DEPTH_LOG2 + OFS;

  dmem_state_t           state, state_n;
  logic [DEPTH_LOG2-1:0] fill, fill_n;
  logic                  fill_we;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      fill  <= '0;
    end else begin
      state <= state_n;
      fill  <= fill_n;
    end
  end

  always_comb begin
    state_n = state;
    fill_n  = fill;
    fill_we = 1'b0;
    unique case (state)
      ST_INIT: begin
        fill_we = 1'b1;
        fill_n  = fill + 1'b1;
        if (fill == '1) state_n = ST_RUN;
      end
      ST_RUN:  state_n = ST_RUN;
      default: state_n = ST_RUN;
    endcase
  end

  assign req_ready = (state == ST_RUN);
  assign init_done = (state == ST_RUN);

  logic                  fire;
  size_dec_t             sz;
  logic [OFS-1:0]        off;
  logic                  misal;
  logic                  oor;
  logic                  err;
  logic [15:0]           be_raw;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wsh;
  logic [DEPTH_LOG2-1:0] idx;

  assign fire   = req_valid & req_ready;
  assign sz     = size_dec(req_rwtyp, DATA_WIDTH == 64);
  assign off    = req_addr[OFS-1:0];
  assign misal  = |(3'(off) & (sz.nbytes[2:0] - 3'd1));
  assign oor    = (req_addr >> HI) != '0;
  assign err    = !sz.legal | misal | oor;
  assign be_raw = (16'd1 << sz.nbytes) - 16'd1;
  assign be     = BYTES'(be_raw << off);
  assign wsh    = req_wdata << {off, 3'b000};
  assign idx    = req_addr[HI-1:OFS];

  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [BYTES-1:0]      arr_be;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Erroring requests never touch the array.
  assign arr_addr  = fill_we ? fill : idx;
  assign arr_be    = fill_we ? '1
                   : (fire & req_we & !err) ? be : '0;
  assign arr_wdata = fill_we ? '0 : wsh;
  assign arr_re    = fire & !req_we & !err;

  emu_dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .addr (arr_addr),
    .be   (arr_be),
    .wdata(arr_wdata),
    .re   (arr_re),
    .rdata(arr_rdata)
  );

  dmem_meta_t meta [RD_LATENCY];
  dmem_meta_t meta_in;

  assign meta_in = {fire, req_we, err, req_rwtyp, 3'(off)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < RD_LATENCY; k++) meta[k] <= '0;
    end else begin
      meta[0] <= meta_in;
      for (int k = 1; k < RD_LATENCY; k++) meta[k] <= meta[k-1];
    end
  end

  logic [DATA_WIDTH-1:0] out_word;

  // The array already registers once, so only RD_LATENCY-1 word stages.
  if (RD_LATENCY == 1) begin : g_nodly
    assign out_word = arr_rdata;
  end else begin : g_dly
    logic [DATA_WIDTH-1:0] wq [RD_LATENCY-1];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k < RD_LATENCY-1; k++) wq[k] <= '0;
      end else begin
        wq[0] <= arr_rdata;
        for (int k = 1; k < RD_LATENCY-1; k++) wq[k] <= wq[k-1];
      end
    end
    assign out_word = wq[RD_LATENCY-2];
  end

  dmem_meta_t            last;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext_w;

  assign last    = meta[RD_LATENCY-1];
  assign shifted = out_word >> {last.off, 3'b000};
  assign ext_w   = DATA_WIDTH'(ext64(64'(shifted), last.rwtyp));

  assign resp_valid = last.valid;
  assign resp_err   = last.valid & last.err;
  assign resp_rdata = (last.valid & !last.we & !last.err) ? ext_w : '0;

endmodule

// File: tb/tb_emu_dmem.sv
// Bench for emu_dmem: three configurations against a byte-level model,
// with directed vectors and hand-computed expectations.
module tb_emu_dmem;
  import emu_mem_pkg::*;

  typedef struct {
    int          due;
    bit          err;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ab, rst_c;
  logic [2:0]  v, w;
  logic [2:0]  typ [3];
  logic [31:0] adr [3];
  logic [63:0] wd  [3];
  logic [2:0]  rdy, rv, re, idn;
  logic [31:0] rd_a, rd_c;
  logic [63:0] rd_b;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int dwb [3] = '{4, 8, 4};
  int lat [3] = '{1, 3, 2};
  int dep [3] = '{16, 8, 4};

  logic [7:0] mem [longint];
  exp_t q0[$], q1[$], q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  emu_dmem #(.DATA_WIDTH(32), .DEPTH_LOG2(16), .RD_LATENCY(1),
             .INIT_ZERO(0)) u_a (
    .clk(clk), .rstn(rst_ab), .req_valid(v[0]), .req_ready(rdy[0]),
    .req_we(w[0]), .req_rwtyp(typ[0]), .req_addr(adr[0]),
    .req_wdata(wd[0][31:0]), .resp_valid(rv[0]), .resp_rdata(rd_a),
    .resp_err(re[0]), .init_done(idn[0]));

  emu_dmem #(.DATA_WIDTH(64), .DEPTH_LOG2(8), .RD_LATENCY(3),
             .INIT_ZERO(0)) u_b (
    .clk(clk), .rstn(rst_ab), .req_valid(v[1]), .req_ready(rdy[1]),
    .req_we(w[1]), .req_rwtyp(typ[1]), .req_addr(adr[1]),
    .req_wdata(wd[1]), .resp_valid(rv[1]), .resp_rdata(rd_b),
    .resp_err(re[1]), .init_done(idn[1]));

  emu_dmem #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .RD_LATENCY(2),
             .INIT_ZERO(1)) u_c (
    .clk(clk), .rstn(rst_c), .req_valid(v[2]), .req_ready(rdy[2]),
    .req_we(w[2]), .req_rwtyp(typ[2]), .req_addr(adr[2]),
    .req_wdata(wd[2][31:0]), .resp_valid(rv[2]), .resp_rdata(rd_c),
    .resp_err(re[2]), .init_done(idn[2]));

  function automatic logic [63:0] rdat(input int k);
    case (k)
      0:       return {32'd0, rd_a};
      1:       return rd_b;
      default: return {32'd0, rd_c};
    endcase
  endfunction

  function automatic longint mkey(input int k, input logic [31:0] a);
    return (longint'(k) << 40) | longint'(a);
  endfunction

  // Byte-addressed little-endian memory; result built from RISC-V rules.
  function automatic void model(
    input  int          k,
    input  bit          st,
    input  logic [2:0]  t,
    input  logic [31:0] a,
    input  logic [63:0] wdat,
    output bit          e,
    output logic [63:0] d
  );
    int          n;
    int          ob;
    logic [63:0] val;
    longint      key;
    n  = 1 << t[1:0];
    ob = (dwb[k] == 8) ? 3 : 2;
    e  = (t == 3'b111)
      || (dwb[k] != 8 && (t == RW_D || t == RW_WU))
      || (a % n != 0)
      || ((a >> (dep[k] + ob)) != 0);
    d = '0;
    if (e) return;
    if (st) begin
      for (int i = 0; i < n; i++) mem[mkey(k, a + i)] = wdat[8*i +: 8];
      return;
    end
    val = '0;
    for (int i = 0; i < n; i++) begin
      key = mkey(k, a + i);
      val |= 64'(mem.exists(key) ? mem[key] : 8'h00) << (8 * i);
    end
    if (!t[2] && n < 8 && val[8*n-1])
      val |= ~((64'd1 << (8 * n)) - 64'd1);
    d = (dwb[k] == 8) ? val : (val & 64'h0000_0000_FFFF_FFFF);
  endfunction

  task automatic push(input int k, input exp_t x);
    case (k)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic check_inst(input int k);
    exp_t        x;
    bit          have;
    logic [63:0] d;
    have = 1'b0;
    d = rdat(k);
    case (k)
      0: if (q0.size() > 0 && q0[0].due == cyc) begin
        have = 1'b1; x = q0.pop_front();
      end
      1: if (q1.size() > 0 && q1[0].due == cyc) begin
        have = 1'b1; x = q1.pop_front();
      end
      default: if (q2.size() > 0 && q2[0].due == cyc) begin
        have = 1'b1; x = q2.pop_front();
      end
    endcase
    if (have) begin
      tests++;
      if (rv[k] !== 1'b1 || re[k] !== x.err || d !== x.data) begin
        fails++;
        $display("FAIL resp inst%0d cyc%0d: got v=%b err=%b data=%h, want v=1 err=%b data=%h",
                 k, cyc, rv[k], re[k], d, x.err, x.data);
      end
    end else if (rv[k] !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL spurious inst%0d cyc%0d: got v=%b, want v=0",
               k, cyc, rv[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) check_inst(k);
    end
  end

  task automatic expect_val(input string name, input logic [63:0] got,
                            input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic req(
    input int          k,
    input bit          st,
    input logic [2:0]  t,
    input logic [31:0] a,
    input logic [63:0] wdat,
    input bit          chk  = 1'b0,
    input bit          lerr = 1'b0,
    input logic [63:0] lit  = 64'd0
  );
    exp_t x;
    @(posedge clk);
    #1;
    v[k]   = 1'b1;
    w[k]   = st;
    typ[k] = t;
    adr[k] = a;
    wd[k]  = wdat;
    model(k, st, t, a, wdat, x.err, x.data);
    x.due = cyc + lat[k];
    if (chk) begin
      tests++;
      if (x.err !== lerr || x.data !== lit) begin
        fails++;
        $display("FAIL model inst%0d a=%h t=%0d: got err=%b data=%h, want err=%b data=%h",
                 k, a, t, x.err, x.data, lerr, lit);
      end
    end
    push(k, x);
  endtask

  task automatic idle(input int k);
    @(posedge clk);
    #1;
    v[k] = 1'b0;
  endtask

  task automatic count_fill(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy[2]) break;
      n++;
    end
  endtask

  int n;

  initial begin
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    v = '0;
    w = '0;
    for (int k = 0; k < 3; k++) begin
      typ[k] = '0;
      adr[k] = '0;
      wd[k]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    expect_val("rst resp_valid", 64'(rv), 64'd0);
    expect_val("rst resp_err", 64'(re), 64'd0);
    expect_val("rst rdata a", 64'(rd_a), 64'd0);
    expect_val("rst rdata b", rd_b, 64'd0);
    expect_val("rst rdata c", 64'(rd_c), 64'd0);
    expect_val("rst req_ready", 64'(rdy), 64'b011);
    expect_val("rst init_done", 64'(idn), 64'b011);
    chk_en = 1'b1;
    rst_ab = 1'b1;
    rst_c  = 1'b1;

    // Zero-fill: interrupted at cycle 8, then a full restart.
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!rdy[2]) n++;
    end
    expect_val("fill busy 8 cycles", 64'(n), 64'd8);
    @(posedge clk);
    #1;
    rst_c = 1'b0;
    #1;
    expect_val("midfill rst ready", 64'(rdy[2]), 64'd0);
    expect_val("midfill rst done", 64'(idn[2]), 64'd0);
    @(posedge clk);
    #1;
    rst_c = 1'b1;
    count_fill(n);
    expect_val("fill cycles", 64'(n), 64'd16);
    expect_val("init_done after fill", 64'(idn[2]), 64'd1);

    // 32-bit, latency 1: extension, byte merge, errors.
    req(0, 1, RW_W,  32'h100, 64'hDEADBEEF, 1, 0, 64'd0);
    req(0, 0, RW_B,  32'h103, 64'd0, 1, 0, 64'hFFFFFFDE);
    req(0, 0, RW_BU, 32'h103, 64'd0, 1, 0, 64'h000000DE);
    req(0, 0, RW_HU, 32'h102, 64'd0, 1, 0, 64'h0000DEAD);
    req(0, 0, RW_H,  32'h100, 64'd0, 1, 0, 64'hFFFFBEEF);
    req(0, 1, RW_B,  32'h101, 64'h55, 1, 0, 64'd0);
    req(0, 0, RW_W,  32'h100, 64'd0, 1, 0, 64'hDEAD55EF);
    req(0, 1, RW_W,  32'h102, 64'h11223344, 1, 1, 64'd0);
    req(0, 0, RW_H,  32'h101, 64'd0, 1, 1, 64'd0);
    req(0, 1, RW_W,  32'h40100, 64'h99999999, 1, 1, 64'd0);
    req(0, 0, RW_W,  32'h100, 64'd0, 1, 0, 64'hDEAD55EF);
    req(0, 0, RW_W,  32'h40000, 64'd0, 1, 1, 64'd0);
    req(0, 0, RW_D,  32'h100, 64'd0, 1, 1, 64'd0);
    req(0, 0, RW_WU, 32'h100, 64'd0, 1, 1, 64'd0);
    req(0, 0, 3'b111, 32'h100, 64'd0, 1, 1, 64'd0);
    req(0, 1, RW_H,  32'h202, 64'h8001, 1, 0, 64'd0);
    req(0, 0, RW_W,  32'h200, 64'd0);
    req(0, 0, RW_H,  32'h202, 64'd0, 1, 0, 64'hFFFF8001);
    idle(0);

    // 64-bit, latency 3: back-to-back traffic and extensions.
    req(1, 1, RW_D, 32'h20, 64'hA0A0_0000_0000_0001);
    req(1, 1, RW_D, 32'h28, 64'hB0B0_0000_0000_0002);
    req(1, 1, RW_D, 32'h30, 64'hC0C0_0000_0000_0003);
    req(1, 1, RW_D, 32'h38, 64'hD0D0_0000_0000_0004);
    req(1, 0, RW_D, 32'h20, 64'd0, 1, 0, 64'hA0A0_0000_0000_0001);
    req(1, 0, RW_D, 32'h28, 64'd0, 1, 0, 64'hB0B0_0000_0000_0002);
    req(1, 0, RW_D, 32'h30, 64'd0, 1, 0, 64'hC0C0_0000_0000_0003);
    req(1, 0, RW_D, 32'h38, 64'd0, 1, 0, 64'hD0D0_0000_0000_0004);
    req(1, 1, RW_D, 32'h40, 64'h0123_4567_89AB_CDEF);
    req(1, 0, RW_D, 32'h40, 64'd0, 1, 0, 64'h0123_4567_89AB_CDEF);
    req(1, 1, RW_D, 32'h8, 64'h8000_0000_1234_5678);
    req(1, 0, RW_W,  32'hC, 64'd0, 1, 0, 64'hFFFF_FFFF_8000_0000);
    req(1, 0, RW_WU, 32'hC, 64'd0, 1, 0, 64'h0000_0000_8000_0000);
    req(1, 0, RW_W,  32'h8, 64'd0, 1, 0, 64'h0000_0000_1234_5678);
    req(1, 0, RW_B,  32'hF, 64'd0, 1, 0, 64'hFFFF_FFFF_FFFF_FF80);
    req(1, 0, RW_BU, 32'h9, 64'd0, 1, 0, 64'h0000_0000_0000_0056);
    req(1, 0, RW_H,  32'hE, 64'd0, 1, 0, 64'hFFFF_FFFF_FFFF_8000);
    req(1, 0, RW_D,  32'h4, 64'd0, 1, 1, 64'd0);
    req(1, 0, RW_D,  32'h800, 64'd0, 1, 1, 64'd0);
    idle(1);

    // Zero-filled memory, latency 2.
    req(2, 0, RW_W,  32'h0,  64'd0, 1, 0, 64'd0);
    req(2, 0, RW_W,  32'h14, 64'd0, 1, 0, 64'd0);
    req(2, 0, RW_W,  32'h3C, 64'd0, 1, 0, 64'd0);
    req(2, 0, RW_W,  32'h40, 64'd0, 1, 1, 64'd0);
    req(2, 1, RW_W,  32'h8,  64'hCAFEF00D);
    req(2, 0, RW_HU, 32'hA,  64'd0, 1, 0, 64'h0000CAFE);
    req(2, 0, RW_B,  32'h8,  64'd0, 1, 0, 64'h0000000D);
    idle(2);

    repeat (8) @(posedge clk);
    #1;
    expect_val("drain a", 64'(q0.size()), 64'd0);
    expect_val("drain b", 64'(q1.size()), 64'd0);
    expect_val("drain c", 64'(q2.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
